// File: rtl/fifo_msg_pkg.sv
// Shared definitions for the message FIFO drain: default parameters, FSM state
// codes and the header length legality check.
package fifo_msg_pkg;

    localparam int unsigned DEF_WIDTH     = 64;
    localparam int unsigned DEF_LEN_W     = 8;
    localparam int unsigned DEF_MAX_LEN   = 64;
    localparam int unsigned DEF_IPG_WORDS = 2;
    localparam logic [63:0] DEF_IDLE_PATTERN = 64'h0707070707070707;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_GAP     = 2'd2;

    // A header is usable only if it announces 1..max_len payload words.
    function automatic logic hdr_len_ok(input int unsigned len, input int unsigned max_len);
        return (len != 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/fifo_msg_drain_out.sv
// Registered tx output stage; it advances only when the current word is
// absent or being accepted, so backpressure freezes every tx_* output.
module msg_out_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tx_ready,
    input  logic             i_ld_valid,
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic             i_ld_sop,
    input  logic             i_ld_eop,
    input  logic             i_ld_idle,
    output logic             o_adv,
    output logic             o_tx_valid,
    output logic [WIDTH-1:0] o_tx_data,
    output logic             o_tx_sop,
    output logic             o_tx_eop,
    output logic             o_tx_idle
);

    assign o_adv = ~o_tx_valid | i_tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            o_tx_sop   <= 1'b0;
            o_tx_eop   <= 1'b0;
            o_tx_idle  <= 1'b0;
        end else if (o_adv) begin
            o_tx_valid <= i_ld_valid;
            o_tx_data  <= i_ld_data;
            o_tx_sop   <= i_ld_sop;
            o_tx_eop   <= i_ld_eop;
            o_tx_idle  <= i_ld_idle;
        end
    end

endmodule

// File: rtl/fifo_msg_drain.sv
// Drains length-prefixed messages from a FWFT FIFO into a ready/valid stream
// with SOP/EOP marking, an idle gap after each message and underrun counting.
module fifo_msg_drain
    import fifo_msg_pkg::*;
#(
    parameter int unsigned     WIDTH        = DEF_WIDTH,
    parameter int unsigned     LEN_W        = DEF_LEN_W,
    parameter int unsigned     MAX_LEN      = DEF_MAX_LEN,
    parameter int unsigned     IPG_WORDS    = DEF_IPG_WORDS,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = WIDTH'(DEF_IDLE_PATTERN)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic             tx_idle,
    output logic             err_bad_len,
    output logic [15:0]      underrun_cnt
);

    localparam logic [7:0] GAP_LAST  = (IPG_WORDS > 0) ? 8'(IPG_WORDS - 1) : 8'd0;
    localparam logic [1:0] AFTER_EOP = (IPG_WORDS > 0) ? ST_GAP : ST_IDLE;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_rem;
    logic [7:0]       r_gcnt;
    logic [15:0]      r_underrun;
    logic             r_err;

    logic             w_adv;
    logic [LEN_W-1:0] w_len;
    logic             w_len_ok;
    logic             w_last;
    logic             w_ld_valid;
    logic [WIDTH-1:0] w_ld_data;
    logic             w_ld_sop;
    logic             w_ld_eop;
    logic             w_ld_idle;

    assign w_len    = fifo_data[LEN_W-1:0];
    assign w_len_ok = hdr_len_ok(32'(w_len), MAX_LEN);
    assign w_last   = (r_rem == LEN_W'(1));

    // Reset gating keeps the FIFO untouched while the block is being cleared.
    assign fifo_rd = ~reset & w_adv & ~fifo_empty &
                     ((r_state == ST_IDLE) || (r_state == ST_PAYLOAD));

    assign err_bad_len  = r_err;
    assign underrun_cnt = r_underrun;

    always_comb begin
        w_ld_valid = 1'b0;
        w_ld_data  = '0;
        w_ld_sop   = 1'b0;
        w_ld_eop   = 1'b0;
        w_ld_idle  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (~fifo_empty && w_len_ok) begin
                    w_ld_valid = 1'b1;
                    w_ld_sop   = 1'b1;
                    w_ld_data  = fifo_data;
                end
            end
            ST_PAYLOAD: begin
                if (~fifo_empty) begin
                    w_ld_valid = 1'b1;
                    w_ld_data  = fifo_data;
                    w_ld_eop   = w_last;
                end
            end
            ST_GAP: begin
                w_ld_valid = 1'b1;
                w_ld_idle  = 1'b1;
                w_ld_data  = IDLE_PATTERN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_gcnt     <= '0;
            r_underrun <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_adv) begin
                case (r_state)
                    ST_IDLE: begin
                        if (~fifo_empty) begin
                            if (w_len_ok) begin
                                r_rem   <= w_len;
                                r_state <= ST_PAYLOAD;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (~fifo_empty) begin
                            r_rem <= r_rem - LEN_W'(1);
                            if (w_last) begin
                                r_state <= AFTER_EOP;
                                r_gcnt  <= '0;
                            end
                        end else if (r_underrun != 16'hFFFF) begin
                            r_underrun <= r_underrun + 16'd1;
                        end
                    end
                    ST_GAP: begin
                        if (r_gcnt == GAP_LAST) begin
                            r_state <= ST_IDLE;
                            r_gcnt  <= '0;
                        end else begin
                            r_gcnt <= r_gcnt + 8'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    msg_out_reg #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk        (clk),
        .reset      (reset),
        .i_tx_ready (tx_ready),
        .i_ld_valid (w_ld_valid),
        .i_ld_data  (w_ld_data),
        .i_ld_sop   (w_ld_sop),
        .i_ld_eop   (w_ld_eop),
        .i_ld_idle  (w_ld_idle),
        .o_adv      (w_adv),
        .o_tx_valid (tx_valid),
        .o_tx_data  (tx_data),
        .o_tx_sop   (tx_sop),
        .o_tx_eop   (tx_eop),
        .o_tx_idle  (tx_idle)
    );

endmodule

// File: tb/tb_fifo_msg_drain.sv
// Bench for fifo_msg_drain: a queue-based FIFO and a message-level expected
// word stream, checked every cycle, plus a back-to-back instance with no gap.
module tb_fifo_msg_drain;

    localparam logic [63:0] IDLE = 64'h0707070707070707;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        idle;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        fifo_rd;
    logic [63:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [63:0] tx_data;
    logic        tx_sop, tx_eop, tx_idle, err_bad_len;
    logic [15:0] underrun_cnt;

    logic        b2bRd;
    logic [63:0] b2bData = '0;
    logic        b2bEmpty = 1'b1;
    logic        b2bValid;
    logic [63:0] b2bTxData;
    logic        b2bSop, b2bEop, b2bIdle, b2bErr;
    logic [15:0] b2bUnder;

    fifo_msg_drain dut (
        .clk(clk), .reset(reset), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_idle(tx_idle),
        .err_bad_len(err_bad_len), .underrun_cnt(underrun_cnt)
    );

    fifo_msg_drain #(.IPG_WORDS(0)) dutB2b (
        .clk(clk), .reset(reset), .fifo_rd(b2bRd), .fifo_data(b2bData),
        .fifo_empty(b2bEmpty), .tx_valid(b2bValid), .tx_ready(1'b1),
        .tx_data(b2bTxData), .tx_sop(b2bSop), .tx_eop(b2bEop), .tx_idle(b2bIdle),
        .err_bad_len(b2bErr), .underrun_cnt(b2bUnder)
    );

    int          checks = 0;
    int          failures = 0;
    word_t       expQ[$];
    int          expIdx = 0;
    logic [63:0] fifoQ[$];
    logic [63:0] b2bQ[$];
    logic [63:0] pend[$];
    word_t       b2bExp[$];
    word_t       cap0[$];
    int          cap0Cyc[$];
    int          bodyLeft = 0;
    int          expUnder = 0;
    int          expErr = 0;
    int          errSeen = 0;
    int          accCnt = 0;
    int          cycle = 0;
    logic        rdSeen = 1'b0;
    logic        b2bRdSeen = 1'b0;
    logic        rstSeen = 1'b0;
    logic        prevStall = 1'b0;
    logic [63:0] prevData = '0;
    logic [3:0]  prevFlags = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifoQ.size() == 0);
        fifo_data  = fifo_empty ? 64'h0 : fifoQ[0];
        b2bEmpty   = (b2bQ.size() == 0);
        b2bData    = b2bEmpty ? 64'h0 : b2bQ[0];
    endtask

    // Compare process: all per-cycle checks happen on the falling edge.
    task automatic monitorCycle();
        logic stall;
        word_t e;
        rdSeen    = fifo_rd;
        b2bRdSeen = b2bRd;
        rstSeen   = reset;
        checkOutput("b2b_rd_while_empty", {63'b0, b2bRd & b2bEmpty}, 64'h0);
        if (b2bValid && !reset) begin
            cap0.push_back('{b2bTxData, b2bSop, b2bEop, b2bIdle});
            cap0Cyc.push_back(cycle);
        end
        if (reset) begin
            checkOutput("rd_in_reset", {63'b0, fifo_rd}, 64'h0);
            expIdx    = expQ.size();
            expUnder  = 0;
            prevStall = 1'b0;
            return;
        end
        stall = tx_valid & ~tx_ready;
        checkOutput("rd_while_empty", {63'b0, fifo_rd & fifo_empty}, 64'h0);
        if (prevStall) begin
            checkOutput("stall_hold_data", tx_data, prevData);
            checkOutput("stall_hold_flags", {60'b0, tx_valid, tx_sop, tx_eop, tx_idle}, {60'b0, prevFlags});
        end
        if (stall) checkOutput("rd_during_stall", {63'b0, fifo_rd}, 64'h0);
        checkOutput("underrun_cnt", {48'b0, underrun_cnt}, 64'(expUnder));
        if (bodyLeft > 0 && fifo_empty && !stall && expUnder < 65535) expUnder++;
        if (tx_valid && tx_ready) begin
            accCnt++;
            if (expIdx < expQ.size()) begin
                e = expQ[expIdx];
                checkOutput("word_data", tx_data, e.data);
                checkOutput("word_flags", {61'b0, tx_sop, tx_eop, tx_idle}, {61'b0, e.sop, e.eop, e.idle});
                expIdx++;
            end else begin
                checkOutput("unexpected_word", {63'b0, tx_valid}, 64'h0);
            end
        end
        if (err_bad_len) errSeen++;
        prevStall = stall;
        prevData  = tx_data;
        prevFlags = {tx_valid, tx_sop, tx_eop, tx_idle};
    endtask

    // One clock: check at the falling edge, then retire pops just after the rising edge.
    task automatic tick();
        logic [63:0] w;
        @(negedge clk);
        monitorCycle();
        @(posedge clk);
        #1;
        cycle++;
        if (rdSeen && fifoQ.size() > 0) begin
            w = fifoQ.pop_front();
            if (bodyLeft == 0) begin
                if (w[7:0] >= 8'd1 && w[7:0] <= 8'd64) bodyLeft = int'(w[7:0]);
            end else begin
                bodyLeft--;
            end
        end
        if (rstSeen) bodyLeft = 0;
        if (b2bRdSeen && b2bQ.size() > 0) void'(b2bQ.pop_front());
        refresh();
    endtask

    task automatic applyStimulus(input int len, input int nNow);
        logic [63:0] hdr;
        logic [63:0] p;
        hdr = {$urandom(), $urandom()};
        hdr[7:0] = 8'(len);
        pend.delete();
        fifoQ.push_back(hdr);
        if (len >= 1 && len <= 64) begin
            expQ.push_back('{hdr, 1'b1, 1'b0, 1'b0});
            for (int i = 0; i < len; i++) begin
                p = {$urandom(), $urandom()};
                expQ.push_back('{p, 1'b0, (i == len - 1), 1'b0});
                if (i < nNow) fifoQ.push_back(p);
                else pend.push_back(p);
            end
            for (int g = 0; g < 2; g++) expQ.push_back('{IDLE, 1'b0, 1'b0, 1'b1});
        end else begin
            expErr++;
        end
        refresh();
    endtask

    task automatic pushRest();
        while (pend.size() > 0) fifoQ.push_back(pend.pop_front());
        refresh();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expIdx < expQ.size() && n < 2000) begin
            tick();
            n++;
        end
        checkOutput({name, "_drained"}, 64'(expIdx), 64'(expQ.size()));
        for (int k = 0; k < 4; k++) tick();
        checkOutput({name, "_err_pulses"}, 64'(errSeen), 64'(expErr));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int start;
        int n;
        int len;
        int r;
        logic [63:0] w;
        logic [0:9] pat;

        refresh();
        tick();
        tick();
        checkOutput("reset_valid_flags", {59'b0, tx_valid, tx_sop, tx_eop, tx_idle, err_bad_len}, 64'h0);
        checkOutput("reset_data", tx_data, 64'h0);
        checkOutput("reset_underrun", {48'b0, underrun_cnt}, 64'h0);
        reset = 1'b0;

        // Two len=2 messages for the gapless instance.
        for (int m = 0; m < 2; m++) begin
            w = {$urandom(), $urandom()};
            w[7:0] = 8'd2;
            b2bQ.push_back(w);
            b2bExp.push_back('{w, 1'b1, 1'b0, 1'b0});
            for (int i = 0; i < 2; i++) begin
                w = {$urandom(), $urandom()};
                b2bQ.push_back(w);
                b2bExp.push_back('{w, 1'b0, (i == 1), 1'b0});
            end
        end

        $display("[TB] normal message");
        base = accCnt;
        applyStimulus(3, 3);
        drain("normal");
        checkOutput("normal_word_count", 64'(accCnt - base), 64'd6);
        checkOutput("normal_idle_after", {63'b0, tx_valid}, 64'h0);

        checkOutput("b2b_count", 64'(cap0.size()), 64'd6);
        if (cap0.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checkOutput("b2b_contiguous", 64'(cap0Cyc[i] - cap0Cyc[0]), 64'(i));
                checkOutput("b2b_data", cap0[i].data, b2bExp[i].data);
                checkOutput("b2b_flags", {61'b0, cap0[i].sop, cap0[i].eop, cap0[i].idle},
                            {61'b0, (i == 0 || i == 3), (i == 2 || i == 5), 1'b0});
            end
        end

        $display("[TB] bad length");
        base = errSeen;
        applyStimulus(0, 0);
        applyStimulus(65, 0);
        applyStimulus(1, 1);
        drain("badlen");
        checkOutput("badlen_pulses", 64'(errSeen - base), 64'd2);

        $display("[TB] backpressure");
        pat = 10'b1001101001;
        applyStimulus(4, 4);
        n = 0;
        while (expIdx < expQ.size() && n < 60) begin
            tx_ready = pat[n % 10];
            tick();
            n++;
        end
        tx_ready = 1'b1;
        drain("backpressure");

        $display("[TB] underrun");
        base = int'(underrun_cnt);
        applyStimulus(4, 2);
        for (int k = 0; k < 8; k++) tick();
        checkOutput("underrun_delta", 64'(int'(underrun_cnt) - base), 64'd5);
        pushRest();
        drain("underrun");

        $display("[TB] randomized messages");
        for (int m = 0; m < 30; m++) begin
            r = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = $urandom_range(65, 255);
            else if (r == 2) len = 64;
            else len = $urandom_range(1, 12);
            applyStimulus(len, $urandom_range(0, (len >= 1 && len <= 64) ? len : 0));
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                tx_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            pushRest();
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                tx_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        tx_ready = 1'b1;
        drain("random");

        $display("[TB] reset mid-payload");
        start = expQ.size();
        applyStimulus(3, 1);
        n = 0;
        while (expIdx < start + 2 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("midreset_reached", 64'(expIdx), 64'(start + 2));
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_flags", {59'b0, tx_valid, tx_sop, tx_eop, tx_idle, err_bad_len}, 64'h0);
        checkOutput("midreset_data", tx_data, 64'h0);
        checkOutput("midreset_underrun", {48'b0, underrun_cnt}, 64'h0);
        applyStimulus(1, 1);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_msg_drain.md
Name: fifo_msg_drain

Overview:
- Downstream consumer of the 64-bit message FIFO buffer.
- Pops words from the FIFO's first-word-fall-through read port. Words arrive as length-prefixed messages: one header word, then the payload words.
- Re-emits each message as a ready/valid word stream with SOP/EOP markers, then inserts a fixed inter-message gap of idle words for the PHY TX path.
- Flags bad headers and counts cycles lost to FIFO underrun.

Parameters:
- WIDTH, 64, data word width; must match the FIFO.
- LEN_W, 8, width of the length field, located at header[LEN_W-1:0].
- MAX_LEN, 64, largest legal payload length in words.
- IPG_WORDS, 2, number of idle words after each EOP; 0 means no gap.
- IDLE_PATTERN, 64'h0707070707070707, data value driven on idle words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fifo_rd  out  1  pop strobe to FIFO rd; combinational
- fifo_data  in  WIDTH  FIFO r_data; valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- tx_valid  out  1  output word valid (registered)
- tx_ready  in  1  downstream accepts the word when tx_valid & tx_ready
- tx_data  out  WIDTH  output word (registered)
- tx_sop  out  1  output word is a header (registered)
- tx_eop  out  1  output word is the last payload word (registered)
- tx_idle  out  1  output word is a gap idle word (registered)
- err_bad_len  out  1  one-cycle pulse when a header is dropped
- underrun_cnt  out  16  saturating count of underrun stall cycles

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; tx_valid, tx_sop, tx_eop, tx_idle, err_bad_len = 0.
  - tx_data=0, underrun_cnt=0, internal counters=0.
  - A message in flight is abandoned; the FIFO is not touched.
- Output-register advance condition: adv = ~tx_valid | tx_ready. The output registers change only when adv=1; otherwise every tx_* output holds.
- fifo_rd = adv & ~fifo_empty & (state is IDLE or PAYLOAD).
  - fifo_rd is never asserted while fifo_empty=1.
  - fifo_rd is never asserted in GAP.
- IDLE:
  - adv & ~fifo_empty: pop the header and compute len = fifo_data[LEN_W-1:0].
    - len in 1..MAX_LEN: tx_valid=1, tx_sop=1, tx_data=header; load rem=len; go to PAYLOAD.
    - len=0 or len>MAX_LEN: the header is popped and discarded; tx_valid=0; err_bad_len=1 for one cycle; stay in IDLE.
  - adv & fifo_empty: tx_valid=0. This is not an underrun.
- PAYLOAD:
  - adv & ~fifo_empty: pop; tx_valid=1, tx_sop=0, tx_data=fifo_data; rem decrements.
    - When rem==1 at the pop: tx_eop=1. Next state is GAP if IPG_WORDS>0, else IDLE.
  - adv & fifo_empty (underrun): tx_valid=0; underrun_cnt+1, saturating at 16'hFFFF; stay in PAYLOAD.
- GAP:
  - On each adv: tx_valid=1, tx_idle=1, tx_data=IDLE_PATTERN, sop=eop=0; gcnt increments.
  - After IPG_WORDS idle words have been loaded, go to IDLE.
  - When IPG_WORDS=0, the block can pop a new header in the cycle after EOP is loaded (back-to-back messages).
- Latency: a word popped in cycle N appears on tx_data in cycle N+1. With tx_ready held high, throughput is one word per cycle.
- Backpressure: while tx_valid & ~tx_ready, nothing is popped, no state changes, and underrun_cnt does not count.
- A one-word message (len=1) gives SOP then EOP on consecutive accepted words.

Decomposition:
- Shared package fifo_msg_pkg holds:
  - State enum: IDLE, PAYLOAD, GAP.
  - Default constants: WIDTH, LEN_W, MAX_LEN, IPG_WORDS, IDLE_PATTERN.
  - Function hdr_len_ok(len).
- One natural sub-module: msg_out_reg, the registered output stage. It owns tx_* and generates adv.
- The FSM, counters and fifo_rd logic stay in fifo_msg_drain.

Test Plan:
- Normal message: FIFO holds hdr 64'h...0003 and P0..P2; tx_ready=1.
  - Required: 4 words, SOP on hdr, EOP on P2.
  - Then 2 idle words of 0707...07.
  - Then tx_valid=0.
- Bad length: headers with len=0 and len=65 (MAX_LEN=64) are pushed.
  - Required: each is popped, err_bad_len pulses once per header, no tx_valid.
  - Required: a following len=1 message is emitted normally.
- Backpressure: tx_ready toggles 1,0,0,1 during the payload.
  - Required: tx_data and flags hold while stalled.
  - Required: fifo_rd=0 during the stall; no word is lost or duplicated.
- Underrun: hdr len=4 with only 2 payload words present; the last 2 words are pushed 5 cycles later.
  - Required: underrun_cnt increments once per stalled cycle; EOP appears on word 4.
- Back-to-back with IPG_WORDS=0: two len=2 messages are preloaded.
  - Required: 6 contiguous valid words, with SOP/EOP at indices 0/2 and 3/5.
- Reset mid-payload: assert reset after 1 of 3 payload words.
  - Required: next cycle all tx_* = 0, underrun_cnt=0, state IDLE.
  - Required: the next FIFO word is treated as a header.
